// File: rtl/tc_cfg_pkg.sv
// ============================================================================
// Module : tc_cfg_pkg
// Brief  : Shared FSM encoding, default sizes and entry type for the TC config bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tc_cfg_pkg;

    localparam int TC_NUM_DEF      = 8;
    localparam int TC_ADDR_LEN_DEF = 3;
    localparam int TC_TYPE_LEN_DEF = 2;

    localparam logic [0:0] TC_CFG_IDLE  = 1'b0;
    localparam logic [0:0] TC_CFG_CLEAR = 1'b1;

    typedef struct packed {
        logic                       enable;
        logic [TC_TYPE_LEN_DEF-1:0] typ;
    } tc_cfg_entry_t;

endpackage

`default_nettype wire

// File: rtl/tc_config_bank_if.sv
// ============================================================================
// Module : tc_config_bank_if
// Brief  : Write/commit/clear/read-back bus of the TC config bank (lock ports under TC_CFG_LOCK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tc_config_bank_if #(
    parameter int TC_NUM      = tc_cfg_pkg::TC_NUM_DEF,
    parameter int TC_ADDR_LEN = tc_cfg_pkg::TC_ADDR_LEN_DEF,
    parameter int TC_TYPE_LEN = tc_cfg_pkg::TC_TYPE_LEN_DEF
);
    logic                          wr_en;
    logic [TC_ADDR_LEN-1:0]        wr_addr;
    logic                          wr_enable;
    logic [TC_TYPE_LEN-1:0]        wr_type;
    logic                          commit;
    logic                          clr_req;
    logic                          busy;
    logic [TC_ADDR_LEN-1:0]        rd_addr;
    logic                          rd_enable;
    logic [TC_TYPE_LEN-1:0]        rd_type;
    logic [TC_NUM-1:0]             en_out;
    logic [TC_NUM*TC_TYPE_LEN-1:0] type_out;
    logic [TC_NUM-1:0]             changed;
`ifdef TC_CFG_LOCK_EN
    logic                          lock_set;
    logic [TC_NUM-1:0]             lock_out;

    modport master (
        output wr_en, wr_addr, wr_enable, wr_type, commit, clr_req, rd_addr, lock_set,
        input  busy, rd_enable, rd_type, en_out, type_out, changed, lock_out
    );
    modport slave (
        input  wr_en, wr_addr, wr_enable, wr_type, commit, clr_req, rd_addr, lock_set,
        output busy, rd_enable, rd_type, en_out, type_out, changed, lock_out
    );
`else
    modport master (
        output wr_en, wr_addr, wr_enable, wr_type, commit, clr_req, rd_addr,
        input  busy, rd_enable, rd_type, en_out, type_out, changed
    );
    modport slave (
        input  wr_en, wr_addr, wr_enable, wr_type, commit, clr_req, rd_addr,
        output busy, rd_enable, rd_type, en_out, type_out, changed
    );
`endif
endinterface

`default_nettype wire

// File: rtl/tc_cfg_clear_seq.sv
// ============================================================================
// Module : tc_cfg_clear_seq
// Brief  : IDLE/CLEAR sequencer walking a channel index from 0 to TC_NUM-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_cfg_clear_seq
    import tc_cfg_pkg::*;
#(
    parameter int TC_NUM      = TC_NUM_DEF,
    parameter int TC_ADDR_LEN = TC_ADDR_LEN_DEF
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   i_clr_req,
    output logic                        o_busy,
    output logic                        o_clr_valid,
    output logic [TC_ADDR_LEN-1:0]      o_clr_idx
);
    logic [0:0]             r_state;
    logic [0:0]             w_next_state;
    logic [TC_ADDR_LEN-1:0] r_idx;
    logic                   w_last;

    assign w_last = (r_idx == TC_ADDR_LEN'(TC_NUM - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TC_CFG_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == TC_CFG_CLEAR && !w_last)
                r_idx <= r_idx + 1'b1;
            else
                r_idx <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TC_CFG_IDLE:  if (i_clr_req) w_next_state = TC_CFG_CLEAR;
            TC_CFG_CLEAR: if (w_last)    w_next_state = TC_CFG_IDLE;
            default:                     w_next_state = TC_CFG_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        o_clr_valid = 1'b0;
        o_clr_idx   = r_idx;
        if (r_state == TC_CFG_CLEAR) begin
            o_busy      = 1'b1;
            o_clr_valid = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tc_config_bank.sv
// ============================================================================
// Module : tc_config_bank
// Brief  : Shadow/active enable+type bank with commit, clear-all and read-back.
//          Optional per-channel write lock when TC_CFG_LOCK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_config_bank
    import tc_cfg_pkg::*;
#(
    parameter int TC_NUM      = TC_NUM_DEF,
    parameter int TC_ADDR_LEN = TC_ADDR_LEN_DEF,
    parameter int TC_TYPE_LEN = TC_TYPE_LEN_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    tc_config_bank_if.slave bus
);
    typedef struct packed {
        logic                   enable;
        logic [TC_TYPE_LEN-1:0] typ;
    } entry_t;

    logic                   w_busy;
    logic                   w_clr_valid;
    logic [TC_ADDR_LEN-1:0] w_clr_idx;
    logic                   w_wr;
    logic                   w_commit;
    entry_t                 w_wr_in;
    entry_t                 w_act_arr [TC_NUM];
    entry_t                 r_rd;

    tc_cfg_clear_seq #(
        .TC_NUM      (TC_NUM),
        .TC_ADDR_LEN (TC_ADDR_LEN)
    ) u_clear_seq (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clr_req   (bus.clr_req),
        .o_busy      (w_busy),
        .o_clr_valid (w_clr_valid),
        .o_clr_idx   (w_clr_idx)
    );

    // A clear request in IDLE takes priority and swallows any same-cycle write/commit.
    assign w_wr     = !w_busy && bus.wr_en  && !bus.clr_req;
    assign w_commit = !w_busy && bus.commit && !bus.clr_req;
    assign w_wr_in  = entry_t'({bus.wr_enable, bus.wr_type});

    for (genvar i = 0; i < TC_NUM; i++) begin : g_ch
        entry_t r_sh;
        entry_t r_act;
        entry_t w_sh_nx;
        entry_t w_act_nx;
        logic   r_chg;
        logic   w_locked;
        logic   w_wr_hit;
        logic   w_clr_hit;

`ifdef TC_CFG_LOCK_EN
        logic r_lock;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_lock <= 1'b0;
            else if (w_wr_hit && bus.lock_set)
                r_lock <= 1'b1;
        end
        assign w_locked        = r_lock;
        assign bus.lock_out[i] = r_lock;
`else
        assign w_locked = 1'b0;
`endif

        assign w_wr_hit  = w_wr && (bus.wr_addr == TC_ADDR_LEN'(i)) && !w_locked;
        assign w_clr_hit = w_clr_valid && (w_clr_idx == TC_ADDR_LEN'(i)) && !w_locked;

        // Commit takes the post-write shadow so a same-cycle write is included.
        always_comb begin
            w_sh_nx  = r_sh;
            w_act_nx = r_act;
            if (w_clr_hit) begin
                w_sh_nx  = '0;
                w_act_nx = '0;
            end else begin
                if (w_wr_hit)
                    w_sh_nx = w_wr_in;
                if (w_commit && !w_locked)
                    w_act_nx = w_sh_nx;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sh  <= '0;
                r_act <= '0;
                r_chg <= 1'b0;
            end else begin
                r_sh  <= w_sh_nx;
                r_act <= w_act_nx;
                r_chg <= (w_act_nx != r_act);
            end
        end

        assign w_act_arr[i]                            = r_act;
        assign bus.en_out[i]                           = r_act.enable;
        assign bus.type_out[i*TC_TYPE_LEN +: TC_TYPE_LEN] = r_act.typ;
        assign bus.changed[i]                          = r_chg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rd <= '0;
        else if (32'(bus.rd_addr) < TC_NUM)
            r_rd <= w_act_arr[bus.rd_addr];
        else
            r_rd <= '0;
    end

    assign bus.rd_enable = r_rd.enable;
    assign bus.rd_type   = r_rd.typ;
    assign bus.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_tc_config_bank.sv
// ============================================================================
// Module : tb_tc_config_bank
// Brief  : Directed self-checking bench for tc_config_bank (8- and 6-channel builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tc_config_bank;
    import tc_cfg_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    tc_config_bank_if #(.TC_NUM(8)) bus8 ();
    tc_config_bank_if #(.TC_NUM(6)) bus6 ();

    tc_config_bank #(.TC_NUM(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
    tc_config_bank #(.TC_NUM(6)) u_dut6 (.clk(clk), .reset_n(reset_n), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input int addr, input logic en, input logic [1:0] typ);
        bus8.wr_en     = 1'b1;
        bus8.wr_addr   = 3'(addr);
        bus8.wr_enable = en;
        bus8.wr_type   = typ;
    endtask

    task automatic idle8();
        bus8.wr_en   = 1'b0;
        bus8.commit  = 1'b0;
        bus8.clr_req = 1'b0;
`ifdef TC_CFG_LOCK_EN
        bus8.lock_set = 1'b0;
`endif
    endtask

    initial begin
        tc_cfg_entry_t e;
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        idle8();
        bus8.wr_addr = '0; bus8.wr_enable = 1'b0; bus8.wr_type = '0; bus8.rd_addr = '0;
        bus6.wr_en = 1'b0; bus6.commit = 1'b0; bus6.clr_req = 1'b0;
        bus6.wr_addr = '0; bus6.wr_enable = 1'b0; bus6.wr_type = '0; bus6.rd_addr = '0;
`ifdef TC_CFG_LOCK_EN
        bus6.lock_set = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_out",  32'(bus8.en_out),   32'h0);
        check("rst_type",    32'(bus8.type_out), 32'h0);
        check("rst_busy",    32'(bus8.busy),     32'h0);
        check("rst_changed", 32'(bus8.changed),  32'h0);
        reset_n = 1'b1;
        tick();

        // Test 1: write without commit, then commit
        wr8(3, 1'b1, 2'd2);
        tick();
        idle8();
        check("t1_nocommit_en",   32'(bus8.en_out),   32'h0);
        check("t1_nocommit_type", 32'(bus8.type_out), 32'h0);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t1_commit_en",   32'(bus8.en_out),   32'h08);
        check("t1_commit_type", 32'(bus8.type_out), 32'h0080);
        check("t1_changed",     32'(bus8.changed),  32'h08);
        bus8.rd_addr = 3'd3;
        tick();
        check("t1_changed_gone", 32'(bus8.changed), 32'h00);
        e = tc_cfg_entry_t'({bus8.rd_enable, bus8.rd_type});
        check("t4_rd_enable", 32'(e.enable), 32'h1);
        check("t4_rd_type",   32'(e.typ),    32'h2);

        // Test 2: same-cycle write and commit, then a no-op commit
        wr8(5, 1'b1, 2'd1);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t2_bypass_en",   32'(bus8.en_out),   32'h28);
        check("t2_bypass_type", 32'(bus8.type_out), 32'h0480);
        check("t2_changed",     32'(bus8.changed),  32'h20);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t2_nochange", 32'(bus8.changed), 32'h00);

        // Test 3: all enabled, clear-all with writes/commits during busy
        for (int i = 0; i < 8; i++) begin
            wr8(i, 1'b1, 2'(i));
            tick();
        end
        idle8();
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t3_all_en",   32'(bus8.en_out),   32'hFF);
        check("t3_all_type", 32'(bus8.type_out), 32'hE4E4);
        bus8.clr_req = 1'b1;
        tick();
        idle8();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_busy_%0d", i), 32'(bus8.busy), 32'h1);
            wr8(0, 1'b1, 2'd3);
            bus8.commit = 1'b1;
            tick();
            check($sformatf("t3_en_%0d", i),  32'(bus8.en_out),  (32'hFF << (i + 1)) & 32'hFF);
            check($sformatf("t3_chg_%0d", i), 32'(bus8.changed), 32'h1 << i);
        end
        idle8();
        check("t3_busy_done", 32'(bus8.busy), 32'h0);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t3_busy_write_dropped", 32'(bus8.en_out), 32'h00);

        // Test 5: reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            wr8(i, 1'b1, 2'd3);
            tick();
        end
        idle8();
        bus8.commit = 1'b1;
        tick();
        idle8();
        bus8.clr_req = 1'b1;
        tick();
        idle8();
        repeat (4) tick();
        check("t5_partial_en", 32'(bus8.en_out), 32'hF0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_en",    32'(bus8.en_out),    32'h0);
        check("t5_rst_type",  32'(bus8.type_out),  32'h0);
        check("t5_rst_busy",  32'(bus8.busy),      32'h0);
        check("t5_rst_chg",   32'(bus8.changed),   32'h0);
        check("t5_rst_rd",    32'(bus8.rd_enable), 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        check("t5_idle_busy", 32'(bus8.busy), 32'h0);
        wr8(1, 1'b1, 2'd3);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t5_idle_write", 32'(bus8.en_out), 32'h02);

        // clr_req wins over same-cycle write/commit
        wr8(6, 1'b1, 2'd1);
        bus8.commit  = 1'b1;
        bus8.clr_req = 1'b1;
        tick();
        idle8();
        check("clr_wins_en", 32'(bus8.en_out), 32'h02);
        repeat (8) tick();
        check("clr_wins_done", 32'(bus8.en_out), 32'h00);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("clr_wins_shadow", 32'(bus8.en_out), 32'h00);

`ifdef TC_CFG_LOCK_EN
        // Test 6: locked channel survives write, commit and clear
        wr8(2, 1'b1, 2'd1);
        bus8.lock_set = 1'b1;
        bus8.commit   = 1'b1;
        tick();
        idle8();
        check("t6_locked_en",  32'(bus8.en_out),   32'h04);
        check("t6_lock_out",   32'(bus8.lock_out), 32'h04);
        wr8(2, 1'b0, 2'd0);
        bus8.commit = 1'b1;
        tick();
        idle8();
        check("t6_write_ignored", 32'(bus8.en_out[2]), 32'h1);
        bus8.clr_req = 1'b1;
        tick();
        idle8();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_clear_%0d", i), 32'(bus8.en_out[2]), 32'h1);
            tick();
        end
        check("t6_type_kept", 32'(bus8.type_out), 32'h0010);
`endif

        // Test 4: six-channel build, out-of-range read and write
        bus6.wr_en = 1'b1; bus6.wr_addr = 3'd7; bus6.wr_enable = 1'b1; bus6.wr_type = 2'd3;
        bus6.commit = 1'b1; bus6.rd_addr = 3'd7;
        tick();
        bus6.wr_en = 1'b0; bus6.commit = 1'b0;
        check("t4_oor_write_en",  32'(bus6.en_out),  32'h00);
        check("t4_oor_write_chg", 32'(bus6.changed), 32'h00);
        bus6.wr_en = 1'b1; bus6.wr_addr = 3'd5; bus6.wr_enable = 1'b1; bus6.wr_type = 2'd2;
        bus6.commit = 1'b1;
        tick();
        bus6.wr_en = 1'b0; bus6.commit = 1'b0;
        check("t4_ch5_en",   32'(bus6.en_out),   32'h20);
        check("t4_ch5_type", 32'(bus6.type_out), 32'h800);
        tick();
        check("t4_oor_rd_en",   32'(bus6.rd_enable), 32'h0);
        check("t4_oor_rd_type", 32'(bus6.rd_type),   32'h0);
        bus6.rd_addr = 3'd5;
        tick();
        check("t4_rd5_en",   32'(bus6.rd_enable), 32'h1);
        check("t4_rd5_type", 32'(bus6.rd_type),   32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
